// File: rtl/ram_pkg.sv
// Shared definitions for the RAM initiator and its simple_ram target:
// default bus widths and the initiator FSM state encoding.
package ram_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int LEN_W_DEF   = 4;
  localparam int RAM_DEPTH_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAPTURE,
    RSP
  } state_t;

endpackage

// File: rtl/simple_ram.sv
// Single-port RAM with registered read: q reflects the word at addr one cycle later.
// Only the low DEPTH_W address bits select a word, so higher addresses alias.
module simple_ram
  import ram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH_W = RAM_DEPTH_W_DEF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];
  logic [DEPTH_W-1:0] index;
  logic               unused_addr_bits;

  assign index            = addr[DEPTH_W-1:0];
  assign unused_addr_bits = ^addr[ADDR_W-1:DEPTH_W];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[index] <= data;
    end
    q <= mem[index];
  end

endmodule

// File: rtl/ram_initiator.sv
// Request/response front end for simple_ram: single-beat writes and
// incrementing read bursts of 1..2**LEN_W words with a fixed 3-cycle word cadence.
module ram_initiator
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_q
);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [LEN_W-1:0]  remaining_reg;
  logic              req_ready_reg;
  logic              busy_reg;
  logic              ram_wr_reg;
  logic              rsp_valid_reg;
  logic              rsp_last_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  // The working address register drives the RAM directly, so ram_addr
  // always shows the word currently being written or fetched.
  assign ram_addr  = addr_reg;
  assign ram_data  = wdata_reg;
  assign ram_wr    = ram_wr_reg;
  assign req_ready = req_ready_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_last  = rsp_last_reg;
  assign rsp_rdata = rsp_rdata_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      remaining_reg <= '0;
      req_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      ram_wr_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_last_reg  <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      ram_wr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg      <= req_addr;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (req_wr) begin
              wdata_reg  <= req_wdata;
              ram_wr_reg <= 1'b1;
              state_reg  <= WR;
            end else begin
              remaining_reg <= req_len;
              state_reg     <= RD_ISSUE;
            end
          end
        end
        WR: begin
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
        RD_ISSUE: begin
          state_reg <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          rsp_rdata_reg <= ram_q;
          rsp_valid_reg <= 1'b1;
          rsp_last_reg  <= (remaining_reg == '0);
          state_reg     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            if (remaining_reg == '0) begin
              req_ready_reg <= 1'b1;
              busy_reg      <= 1'b0;
              state_reg     <= IDLE;
            end else begin
              addr_reg      <= addr_reg + ADDR_W'(1);
              remaining_reg <= remaining_reg - LEN_W'(1);
              state_reg     <= RD_ISSUE;
            end
          end
        end
        default: begin
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          rsp_valid_reg <= 1'b0;
          rsp_last_reg  <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator driving simple_ram: writes, single reads, bursts,
// response stalls, address wrap and reset in the middle of a burst.
module tb_ram_initiator;

  localparam int ADDR_W = ram_pkg::ADDR_W_DEF;
  localparam int DATA_W = ram_pkg::DATA_W_DEF;
  localparam int LEN_W  = ram_pkg::LEN_W_DEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              busy;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_q;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries are {last, data}; the model memory tracks every write.
  logic [DATA_W:0]   exp_q [$];
  logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];

  always #5 clk = ~clk;

  ram_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .busy(busy),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_q(ram_q)
  );

  simple_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(8)) ram (
    .clk(clk), .addr(ram_addr), .data(ram_data), .wr(ram_wr), .q(ram_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready_before got=%b exp=1", req_ready);
    end
    req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data;
    req_len = LEN_W'($urandom);
    model_mem[addr] = data;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    checks++;
    if (ram_wr !== 1'b1 || ram_addr !== addr || ram_data !== data) begin
      errors++;
      $display("FAIL wr_strobe got wr=%b addr=%h data=%h exp wr=1 addr=%h data=%h",
               ram_wr, ram_addr, ram_data, addr, data);
    end
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wr_busy got ready=%b busy=%b exp ready=0 busy=1", req_ready, busy);
    end
    tick();
    checks++;
    if (ram_wr !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done got wr=%b ready=%b busy=%b exp wr=0 ready=1 busy=0",
               ram_wr, req_ready, busy);
    end
    $display("write addr=%h data=%h", addr, data);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input int len,
                         input int stall_word, input int stall_cycles, input bit noise);
    logic [DATA_W:0]   exp;
    logic [DATA_W-1:0] hold;
    logic [ADDR_W-1:0] a;
    int lat;
    for (int i = 0; i <= len; i++) begin
      a = addr + ADDR_W'(i);
      exp_q.push_back({(i == len), model_mem[a]});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rd_ready_before got=%b exp=1", req_ready);
    end
    req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_len = LEN_W'(len);
    req_wdata = $urandom;
    for (int w = 0; w <= len; w++) begin
      a = addr + ADDR_W'(w);
      lat = 0;
      do begin
        tick();
        lat++;
        if (lat == 1) begin
          if (w == 0) begin
            req_valid = 1'b0; req_addr = $urandom; req_len = LEN_W'($urandom);
          end
          rsp_ready = (w != stall_word);
          checks++;
          if (ram_addr !== a) begin
            errors++; $display("FAIL rd_issue_addr word=%0d got=%h exp=%h", w, ram_addr, a);
          end
        end
        if (noise && lat == 2) begin
          req_valid = 1'b1; req_wr = 1'b1;
        end
        if (noise && lat == 3) begin
          req_valid = 1'b0; req_wr = 1'b0;
        end
      end while (rsp_valid !== 1'b1 && lat < 20);
      checks++;
      if (lat != 3) begin
        errors++; $display("FAIL rd_latency word=%0d got=%0d exp=3", w, lat);
      end
      if (w == stall_word) begin
        hold = rsp_rdata;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          checks++;
          if (rsp_valid !== 1'b1 || rsp_rdata !== hold || ram_addr !== a) begin
            errors++;
            $display("FAIL rd_stall cycle=%0d got valid=%b data=%h addr=%h exp valid=1 data=%h addr=%h",
                     s, rsp_valid, rsp_rdata, ram_addr, hold, a);
          end
        end
        rsp_ready = 1'b1;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rd_unexpected got data=%h exp=none", rsp_rdata);
      end else begin
        exp = exp_q.pop_front();
        if ({rsp_last, rsp_rdata} !== exp) begin
          errors++;
          $display("FAIL rd_data word=%0d got last=%b data=%h exp last=%b data=%h",
                   w, rsp_last, rsp_rdata, exp[DATA_W], exp[DATA_W-1:0]);
        end
      end
      $display("rsp addr=%h data=%h last=%b", a, rsp_rdata, rsp_last);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_done got valid=%b ready=%b busy=%b exp valid=0 ready=1 busy=0",
               rsp_valid, req_ready, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rd_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || ram_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b busy=%b wr=%b exp ready=1 busy=0 wr=0",
               req_ready, busy, ram_wr);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rsp got valid=%b last=%b data=%h exp 0 0 0", rsp_valid, rsp_last, rsp_rdata);
    end
    checks++;
    if (ram_addr !== '0 || ram_data !== '0) begin
      errors++; $display("FAIL reset_ram got addr=%h data=%h exp 0 0", ram_addr, ram_data);
    end
  endtask

  task automatic test_single();
    do_write(32'h0, 32'h01);
    do_read(32'h0, 0, -1, 0, 1'b0);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) do_write(ADDR_W'(4 + i), DATA_W'(32'hA0 + i));
    do_read(32'h4, 3, -1, 0, 1'b1);
  endtask

  task automatic test_burst_stall();
    do_read(32'h4, 3, 1, 5, 1'b0);
  endtask

  task automatic test_wrap();
    do_write(32'hFFFF_FFFF, 32'h55);
    do_read(32'hFFFF_FFFF, 1, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int lat;
    int extra;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h4; req_len = 4'd3;
    rsp_ready = 1'b1;
    lat = 0;
    do begin
      tick(); lat++;
      if (lat == 1) req_valid = 1'b0;
    end while (rsp_valid !== 1'b1 && lat < 20);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[32'h4]) begin
      errors++;
      $display("FAIL rst_burst_w0 got valid=%b data=%h exp valid=1 data=%h",
               rsp_valid, rsp_rdata, model_mem[32'h4]);
    end
    $display("rsp addr=%h data=%h last=%b", 32'h4, rsp_rdata, rsp_last);
    tick();
    rsp_ready = 1'b0;
    lat = 0;
    do begin
      tick(); lat++;
    end while (rsp_valid !== 1'b1 && lat < 20);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL rst_burst_w1_latency got=%0d exp=2", lat);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || ram_wr !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || rsp_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_burst_state got valid=%b wr=%b ready=%b busy=%b last=%b exp 0 0 1 0 0",
               rsp_valid, ram_wr, req_ready, busy, rsp_last);
    end
    rsp_ready = 1'b1;
    extra = 0;
    repeat (15) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL rst_burst_resumed got=%0d active cycles exp=0", extra);
    end
    rsp_ready = 1'b0;
    exp_q.delete();
    $display("reset during burst, idle afterwards");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_burst_stall();
    test_wrap();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_initiator.md
RAM_INITIATOR -- requirements
Module: ram_initiator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, RAM address width.
- DATA_W, 32, RAM data width.
- LEN_W, 4, burst-length field width (bursts of 1..16 words).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset, synchronous, active-low.
- req_valid, in, 1, request offered.
- req_ready, out, 1, request accepted when high together with req_valid.
- req_wr, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, start address.
- req_wdata, in, DATA_W, write data (single beat).
- req_len, in, LEN_W, read burst length minus 1.
- rsp_valid, out, 1, read data presented.
- rsp_ready, in, 1, consumer accepts read data.
- rsp_rdata, out, DATA_W, read word.
- rsp_last, out, 1, final word of a burst.
- busy, out, 1, high in any state other than IDLE.
- ram_data, out, DATA_W, write data to simple_ram.
- ram_addr, out, ADDR_W, address to simple_ram.
- ram_wr, out, 1, write strobe to simple_ram.
- ram_q, in, DATA_W, read data from simple_ram, valid one cycle after ram_addr.

Function
REQ-003 The block SHALL implement an FSM with five states: IDLE, WR, RD_ISSUE, RD_CAPTURE, RSP.
REQ-004 req_ready SHALL be high only in IDLE, so a request is accepted in at most one cycle.
REQ-005 On accept with req_wr=1, the block SHALL go IDLE->WR, latching addr and wdata; req_len is ignored for writes.
REQ-006 In WR the block SHALL assert ram_wr=1 with the latched ram_addr/ram_data for exactly one cycle, then return to IDLE.
REQ-007 On accept with req_wr=0, the block SHALL latch addr and set the remaining count to req_len, then go IDLE->RD_ISSUE.
REQ-008 In RD_ISSUE the block SHALL drive ram_addr with the current address and ram_wr=0, then go to RD_CAPTURE.
REQ-009 In RD_CAPTURE the block SHALL register ram_q into rsp_rdata, set rsp_valid=1, set rsp_last=(remaining==0), then go to RSP.
REQ-010 In RSP, rsp_valid/rsp_rdata/rsp_last SHALL hold stable until rsp_ready=1.
REQ-011 On the RSP handshake, if remaining==0 the block SHALL go to IDLE; otherwise it SHALL increment the address by 1, decrement remaining, and go to RD_ISSUE.
REQ-012 The address increment SHALL wrap modulo 2^ADDR_W, so 0xFFFFFFFF is followed by 0x00000000.
REQ-013 ram_wr SHALL be 0 in every state except WR.
REQ-014 rsp_valid SHALL be 0 outside RSP.
REQ-015 Latency SHALL be fixed:
- Read: accept at cycle N, ram_addr at N+1, rsp_valid at N+3.
- Burst: with rsp_ready held high, 3 cycles per word.
- Write: ram_wr at N+1; req_ready high again at N+2.
REQ-016 req_valid changing while not accepted SHALL have no effect; req_* inputs are sampled only at accept.
REQ-017 Any rsp_ready stall length SHALL be tolerated with no loss or duplication of data.

Reset
REQ-018 With rst_n=0 at a clock edge, the next state SHALL be IDLE; this applies mid-write, mid-burst and while stalled in RSP.
REQ-019 Reset values SHALL be:
- req_ready=1 after reset release.
- rsp_valid=0, rsp_last=0, rsp_rdata=0.
- busy=0, ram_wr=0, ram_addr=0, ram_data=0.
- internal address and count = 0.
REQ-020 A burst interrupted by reset SHALL NOT resume, and no rsp_last SHALL be issued for it.

Structure
REQ-021 The state encoding typedef and the ADDR_W/DATA_W/LEN_W defaults SHALL live in a shared package ram_pkg, also used by simple_ram.
REQ-022 The block SHALL be a single module; no sub-module is required.

Verification
REQ-023 The bench SHALL instantiate ram_initiator connected to simple_ram and cover:
- Write addr=0x0, wdata=0x01 -> ram_wr high exactly one cycle with ram_addr=0x0, ram_data=0x01; req_ready high again 2 cycles after accept.
- Read addr=0x0, len=0, after the write above -> rsp_rdata=0x01, rsp_last=1, rsp_valid 3 cycles after accept.
- Writes 0xA0..0xA3 to addr 4..7, then read addr=4, len=3, rsp_ready=1 -> 4 responses A0,A1,A2,A3 at 3-cycle spacing; rsp_last only on A3.
- Same burst with rsp_ready low for 5 cycles on the 2nd word -> rsp_rdata holds A1 stable; sequence unchanged; no extra ram_addr issued during the stall.
- Read addr=0xFFFFFFFF, len=1 -> second ram_addr=0x00000000.
- rst_n=0 for one cycle during the 2nd word of a 4-word burst -> next cycle IDLE, rsp_valid=0, ram_wr=0, req_ready=1; no further responses.
